// File: rtl/commit_trace_pkg.sv
// Shared types for the commit-trace producer: the buffered retire record.
package commit_trace_pkg;

   localparam int XLEN      = 32;
   localparam int SEQ_W_MAX = 32;

   typedef struct packed {
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      nextpc;
      logic [XLEN-1:0]      inst;
      logic [SEQ_W_MAX-1:0] seq;
   } commit_rec_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// First-word-fall-through sync FIFO of commit records; while empty the
// output holds the last record shown so the trace port does not toggle.
module commit_trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  commit_rec_t       wdata,
   input  logic              pop,
   output commit_rec_t       rdata,
   output logic [CW-1:0]     count
);

   commit_rec_t          mem [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   commit_rec_t          hold_q, hold_d;
   logic                 do_push, do_pop;

   assign do_push = push && (count_q != CW'(DEPTH));
   assign do_pop  = pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      hold_d   = hold_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Track the record currently on the port so it survives going empty.
      if (count_q != '0) hold_d = mem[rd_ptr_q];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !reset) mem[wr_ptr_q] <= wdata;
   end

   assign rdata = (count_q != '0) ? mem[rd_ptr_q] : hold_q;
   assign count = count_q;

endmodule

// File: rtl/commit_trace_src.sv
// Commit-info producer: buffers retired (pc, nextpc, inst) records with a
// sequence number. Define COMMIT_TRACE_CHECK_EN for the pc continuity checker.
module commit_trace_src
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [31:0]      wb_pc,
   input  logic [31:0]      wb_nextpc,
   input  logic [31:0]      wb_inst,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [31:0]      trace_pc,
   output logic [31:0]      trace_nextpc,
   output logic [31:0]      trace_inst,
   output logic [SEQ_W-1:0] trace_seq,
   output logic             flow_err,
   output logic [31:0]      flow_err_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]    count;
   logic             push, pop;
   logic [SEQ_W-1:0] seq_q, seq_d;
   commit_rec_t      wr_rec, rd_rec;

   assign wb_ready    = (count != CW'(DEPTH));
   assign trace_valid = (count != '0);
   assign push        = wb_valid && wb_ready && !reset;
   assign pop         = trace_valid && trace_ready;

   always_comb begin
      wr_rec        = '0;
      wr_rec.pc     = wb_pc;
      wr_rec.nextpc = wb_nextpc;
      wr_rec.inst   = wb_inst;
      wr_rec.seq    = SEQ_W_MAX'(seq_q);
      seq_d         = push ? seq_q + SEQ_W'(1) : seq_q;
   end

   always_ff @(posedge clock) begin
      if (reset) seq_q <= '0;
      else       seq_q <= seq_d;
   end

   commit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .wdata (wr_rec),
      .pop   (pop),
      .rdata (rd_rec),
      .count (count)
   );

   assign trace_pc     = rd_rec.pc;
   assign trace_nextpc = rd_rec.nextpc;
   assign trace_inst   = rd_rec.inst;
   assign trace_seq    = rd_rec.seq[SEQ_W-1:0];

`ifdef COMMIT_TRACE_CHECK_EN
   logic [31:0] last_nextpc_q, last_nextpc_d;
   logic        last_nextpc_vld_q, last_nextpc_vld_d;
   logic        flow_err_q, flow_err_d;
   logic [31:0] flow_err_pc_q, flow_err_pc_d;

   always_comb begin
      last_nextpc_d     = last_nextpc_q;
      last_nextpc_vld_d = last_nextpc_vld_q;
      flow_err_d        = flow_err_q;
      flow_err_pc_d     = flow_err_pc_q;
      if (push) begin
         last_nextpc_d     = wb_nextpc;
         last_nextpc_vld_d = 1'b1;
         // First discontinuity wins; later ones leave the captured pc alone.
         if (last_nextpc_vld_q && (wb_pc != last_nextpc_q)) begin
            flow_err_d = 1'b1;
            if (!flow_err_q) flow_err_pc_d = wb_pc;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_nextpc_q     <= '0;
         last_nextpc_vld_q <= 1'b0;
         flow_err_q        <= 1'b0;
         flow_err_pc_q     <= '0;
      end else begin
         last_nextpc_q     <= last_nextpc_d;
         last_nextpc_vld_q <= last_nextpc_vld_d;
         flow_err_q        <= flow_err_d;
         flow_err_pc_q     <= flow_err_pc_d;
      end
   end

   assign flow_err    = flow_err_q;
   assign flow_err_pc = flow_err_pc_q;
`else
   assign flow_err    = 1'b0;
   assign flow_err_pc = '0;
`endif

endmodule

// File: tb/tb_commit_trace_src.sv
// Directed bench for commit_trace_src with a queue-based reference model.
module tb_commit_trace_src;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0, trace_ready = 1'b0;
   logic [31:0] wb_pc = '0, wb_nextpc = '0, wb_inst = '0;
   logic        wb_ready, trace_valid, flow_err;
   logic [31:0] trace_pc, trace_nextpc, trace_inst, trace_seq, flow_err_pc;

   logic        w_valid = 1'b0, w_tready = 1'b1;
   logic [31:0] w_pc = '0;
   logic        w_ready, w_tvalid, w_ferr;
   logic [31:0] w_tpc, w_tnpc, w_tinst, w_ferr_pc;
   logic [3:0]  w_tseq;

   int checks = 0, failures = 0;
   bit started = 0;
   int popped[$];
   int w_popped[$];

   always #5 clk = ~clk;

   commit_trace_src #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
      .clock(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_pc(wb_pc), .wb_nextpc(wb_nextpc), .wb_inst(wb_inst),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_nextpc(trace_nextpc), .trace_inst(trace_inst),
      .trace_seq(trace_seq), .flow_err(flow_err), .flow_err_pc(flow_err_pc)
   );

   commit_trace_src #(.DEPTH(DEPTH), .SEQ_W(4)) dut_w (
      .clock(clk), .reset(reset), .wb_valid(w_valid), .wb_ready(w_ready),
      .wb_pc(w_pc), .wb_nextpc(w_pc + 32'd4), .wb_inst(32'h13),
      .trace_valid(w_tvalid), .trace_ready(w_tready),
      .trace_pc(w_tpc), .trace_nextpc(w_tnpc), .trace_inst(w_tinst),
      .trace_seq(w_tseq), .flow_err(w_ferr), .flow_err_pc(w_ferr_pc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc, nextpc, inst, seq;
   } rec_t;

   rec_t        mq[$];
   rec_t        last_shown = '0;
   logic [31:0] mseq = '0;
   bit          m_err = 0, m_lvld = 0;
   logic [31:0] m_errpc = '0, m_lastnpc = '0;

   always @(posedge clk) begin
      bit do_push, do_pop;
      if (reset) begin
         mq.delete();
         last_shown = '0;
         mseq = '0;
         m_err = 0; m_lvld = 0; m_errpc = '0; m_lastnpc = '0;
      end else begin
         do_pop  = (mq.size() != 0) && trace_ready;
         do_push = wb_valid && (mq.size() != DEPTH);
         if (mq.size() != 0) last_shown = mq[0];
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back('{wb_pc, wb_nextpc, wb_inst, mseq});
            mseq = mseq + 32'd1;
`ifdef COMMIT_TRACE_CHECK_EN
            if (m_lvld && wb_pc != m_lastnpc) begin
               if (!m_err) m_errpc = wb_pc;
               m_err = 1;
            end
            m_lastnpc = wb_nextpc;
            m_lvld = 1;
`endif
         end
      end
   end

   always @(negedge clk) begin
      rec_t exp;
      if (started) begin
         exp = (mq.size() != 0) ? mq[0] : last_shown;
         chk("trace_valid", trace_valid, mq.size() != 0);
         chk("wb_ready", wb_ready, mq.size() != DEPTH);
         chk("trace_pc", trace_pc, exp.pc);
         chk("trace_nextpc", trace_nextpc, exp.nextpc);
         chk("trace_inst", trace_inst, exp.inst);
         chk("trace_seq", trace_seq, exp.seq);
         chk("flow_err", flow_err, m_err);
         chk("flow_err_pc", flow_err_pc, m_errpc);
         if (trace_valid && trace_ready) popped.push_back(int'(trace_seq));
         if (w_tvalid) w_popped.push_back(int'(w_tseq));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; wb_valid = 0; trace_ready = 0; w_valid = 0;
      step();
      reset = 0;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] inst);
      wb_valid = 1; wb_pc = pc; wb_nextpc = npc; wb_inst = inst;
      step();
      wb_valid = 0;
      $display("push pc=%h nextpc=%h inst=%h", pc, npc, inst);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(); step();
      reset = 0;
      started = 1;
      chk("reset_valid", trace_valid, 1'b0);
      chk("reset_pc", trace_pc, 32'h0);

      // 1. single record
      push(32'h80000000, 32'h80000004, 32'h00000413);
      chk("t1_valid", trace_valid, 1'b1);
      chk("t1_pc", trace_pc, 32'h80000000);
      chk("t1_nextpc", trace_nextpc, 32'h80000004);
      chk("t1_inst", trace_inst, 32'h00000413);
      chk("t1_seq", trace_seq, 32'd0);
      trace_ready = 1;
      step();
      trace_ready = 0;
      chk("t1_drop", trace_valid, 1'b0);
      chk("t1_hold", trace_pc, 32'h80000000);

      // 2. fill / full
      do_reset();
      popped.delete();
      for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 32'h13);
      chk("t2_full", wb_ready, 1'b0);
      wb_valid = 1; wb_pc = 32'h1010; wb_nextpc = 32'h1014; wb_inst = 32'h13;
      step();
      chk("t2_still_full", wb_ready, 1'b0);
      trace_ready = 1;
      step();
      trace_ready = 0;
      chk("t2_ready_back", wb_ready, 1'b1);
      step();
      wb_valid = 0;
      trace_ready = 1;
      for (int i = 0; i < 5; i++) step();
      trace_ready = 0;
      chk("t2_npop", popped.size(), 5);
      if (popped.size() == 5) chk("t2_fifth_seq", popped[4], 4);
      foreach (popped[i]) $display("t2 pop seq=%0d", popped[i]);

      // 3. streaming
      do_reset();
      popped.delete();
      wb_valid = 1; trace_ready = 1;
      for (int i = 0; i < 20; i++) begin
         wb_pc = 32'h2000 + 32'(4 * i); wb_nextpc = wb_pc + 32'd4; wb_inst = 32'(i);
         step();
      end
      wb_valid = 0;
      step();
      trace_ready = 0;
      chk("t3_npop", popped.size(), 20);
      foreach (popped[i]) chk("t3_seq_order", popped[i], i);

`ifdef COMMIT_TRACE_CHECK_EN
      // 4. discontinuity
      do_reset();
      push(32'h80000000, 32'h80000004, 32'h13);
      chk("t4_no_err", flow_err, 1'b0);
      push(32'h80000010, 32'h80000014, 32'h13);
      chk("t4_err", flow_err, 1'b1);
      chk("t4_err_pc", flow_err_pc, 32'h80000010);
      push(32'h80000100, 32'h80000104, 32'h13);
      chk("t4_err_pc_kept", flow_err_pc, 32'h80000010);
      trace_ready = 1; step(); step(); step(); trace_ready = 0;
`endif

      // 5. reset mid-operation
      do_reset();
      push(32'h3000, 32'h3004, 32'h1);
      push(32'h3100, 32'h3104, 32'h2);
      push(32'h3200, 32'h3204, 32'h3);
      reset = 1;
      step();
      reset = 0;
      chk("t5_valid", trace_valid, 1'b0);
      push(32'h4000, 32'h4004, 32'h4);
      chk("t5_seq", trace_seq, 32'd0);
      chk("t5_pc", trace_pc, 32'h4000);
      chk("t5_flow_err", flow_err, 1'b0);

      // 6. sequence wrap with SEQ_W=4
      do_reset();
      w_popped.delete();
      w_valid = 1;
      for (int i = 0; i < 17; i++) begin
         w_pc = 32'h5000 + 32'(4 * i);
         step();
      end
      w_valid = 0;
      step(); step();
      chk("t6_npop", w_popped.size(), 17);
      if (w_popped.size() == 17) begin
         chk("t6_seq15", w_popped[15], 15);
         chk("t6_seq_wrap", w_popped[16], 0);
      end
      foreach (w_popped[i]) chk("t6_seq_mod", w_popped[i], i % 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
